hls_call_driver: RTL

- Synthesizable driver that invokes one method of a generated HLS module through its req/busy/return handshake: it issues the request, waits for completion and captures and checks the return value.
- Sits directly upstream of the generated module's method port (e.g. `<method>_req` / `<method>_busy` / `<method>_return` / `<method>_<arg>`).
- Used both on-chip and as the stimulus/checker core of self-checking simulation benches.
- Repeats the call NUM_CALLS times, incrementing the argument each time, and reports done/pass/timeout.

---
 rtl/hls_call_pkg.sv | 23 ++
 rtl/hls_call_timer.sv | 28 ++
 rtl/hls_call_driver.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/hls_call_pkg.sv
// Shared definitions for the HLS method-call driver: FSM encoding, counter widths and the
// default timing constants reused by other benches.
package hls_call_pkg;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE      = 3'd0;
    localparam state_t ST_DELAY     = 3'd1;
    localparam state_t ST_ISSUE     = 3'd2;
    localparam state_t ST_WAIT_DONE = 3'd3;
    localparam state_t ST_CHECK     = 3'd4;
    localparam state_t ST_FINISH    = 3'd5;

    localparam int unsigned CALLS_W             = 16;
    localparam int unsigned TIMER_W             = 32;
    localparam int unsigned DEFAULT_TIMEOUT     = 10000;
    localparam int unsigned DEFAULT_START_DELAY = 100;

    function automatic logic [CALLS_W-1:0] sat_inc(input logic [CALLS_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/hls_call_timer.sv
// Loadable down-counter that stops at zero and flags it; used for the start delay and the
// per-call timeout.
module hls_call_timer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             dec,
    output logic             zero
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hls_call_driver.sv
// Drives one method of a generated HLS module over req/busy/return, repeating the call
// NUM_CALLS times with a stepped argument and reporting done/pass/timeout.
module hls_call_driver
    import hls_call_pkg::*;
#(
    parameter int unsigned ARG_WIDTH   = 32,
    parameter int unsigned RET_WIDTH   = 32,
    parameter int unsigned START_DELAY = DEFAULT_START_DELAY,
    parameter int unsigned TIMEOUT     = DEFAULT_TIMEOUT,
    parameter int unsigned NUM_CALLS   = 1,
    parameter int unsigned ARG_STEP    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ARG_WIDTH-1:0] arg_init,
    input  logic [RET_WIDTH-1:0] expected,
    output logic                 call_req,
    output logic [ARG_WIDTH-1:0] call_arg,
    input  logic                 call_busy,
    input  logic [RET_WIDTH-1:0] call_return,
    output logic [RET_WIDTH-1:0] last_return,
    output logic [CALLS_W-1:0]   calls_done,
    output logic                 done,
    output logic                 pass,
    output logic                 timeout
);

    // Timers fire on their zero flag, so they are loaded with N-1 to expire after N cycles.
    localparam logic [TIMER_W-1:0] DELAY_LOAD =
        (START_DELAY == 0) ? '0 : TIMER_W'(START_DELAY - 1);
    localparam logic [TIMER_W-1:0] TIMEOUT_LOAD =
        (TIMEOUT == 0) ? '0 : TIMER_W'(TIMEOUT - 1);
    localparam logic [ARG_WIDTH-1:0] ARG_INC   = ARG_WIDTH'(ARG_STEP);
    localparam logic [CALLS_W-1:0]   LAST_CALL = CALLS_W'(NUM_CALLS);

    state_t               state;
    state_t               state_next;
    logic [RET_WIDTH-1:0] expected_value;
    logic                 mismatch;
    logic                 mismatch_next;
    logic                 last_call;
    logic                 delay_load;
    logic                 delay_dec;
    logic                 delay_zero;
    logic                 tmo_load;
    logic                 tmo_dec;
    logic                 tmo_zero;

    hls_call_timer #(
        .WIDTH (TIMER_W)
    ) u_delay_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (delay_load),
        .load_value (DELAY_LOAD),
        .dec        (delay_dec),
        .zero       (delay_zero)
    );

    hls_call_timer #(
        .WIDTH (TIMER_W)
    ) u_timeout_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (tmo_load),
        .load_value (TIMEOUT_LOAD),
        .dec        (tmo_dec),
        .zero       (tmo_zero)
    );

    assign delay_dec     = (state == ST_DELAY);
    assign tmo_dec       = (state == ST_ISSUE) || (state == ST_WAIT_DONE);
    assign mismatch_next = mismatch || (last_return != expected_value);
    assign last_call     = (sat_inc(calls_done) == LAST_CALL);

    always_comb begin
        state_next = state;
        delay_load = 1'b0;
        tmo_load   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    delay_load = 1'b1;
                    if (START_DELAY == 0) begin
                        state_next = ST_ISSUE;
                        tmo_load   = 1'b1;
                    end else begin
                        state_next = ST_DELAY;
                    end
                end
            end
            ST_DELAY: begin
                if (delay_zero) begin
                    state_next = ST_ISSUE;
                    tmo_load   = 1'b1;
                end
            end
            // Progress (ack or completion) takes priority over an expiring timeout.
            ST_ISSUE: begin
                if (call_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (tmo_zero) begin
                    state_next = ST_FINISH;
                end
            end
            ST_WAIT_DONE: begin
                if (!call_busy) begin
                    state_next = ST_CHECK;
                end else if (tmo_zero) begin
                    state_next = ST_FINISH;
                end
            end
            ST_CHECK: begin
                if (last_call) begin
                    state_next = ST_FINISH;
                end else begin
                    state_next = ST_ISSUE;
                    tmo_load   = 1'b1;
                end
            end
            ST_FINISH: state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= ST_IDLE;
            call_req       <= 1'b0;
            call_arg       <= '0;
            expected_value <= '0;
            last_return    <= '0;
            calls_done     <= '0;
            done           <= 1'b0;
            pass           <= 1'b0;
            timeout        <= 1'b0;
            mismatch       <= 1'b0;
        end else begin
            state    <= state_next;
            call_req <= (state_next == ST_ISSUE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        call_arg       <= arg_init;
                        expected_value <= expected;
                        calls_done     <= '0;
                        done           <= 1'b0;
                        pass           <= 1'b0;
                        timeout        <= 1'b0;
                        mismatch       <= 1'b0;
                    end
                end
                ST_ISSUE, ST_WAIT_DONE: begin
                    if ((state == ST_WAIT_DONE) && !call_busy) begin
                        last_return <= call_return;
                    end
                    if (state_next == ST_FINISH) begin
                        timeout <= 1'b1;
                        done    <= 1'b1;
                        pass    <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    mismatch   <= mismatch_next;
                    calls_done <= sat_inc(calls_done);
                    if (last_call) begin
                        done <= 1'b1;
                        pass <= !mismatch_next && !timeout;
                    end else begin
                        call_arg <= call_arg + ARG_INC;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
